// File: rtl/trace_pkg.sv
// Shared trace types: controller state codes and the captured {pc, result} entry.
package trace_pkg;

  localparam int unsigned TRACE_W = 64;
  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] FETCH     = 3'd0;
  localparam logic [STATE_W-1:0] DECODE    = 3'd1;
  localparam logic [STATE_W-1:0] EXECUTE   = 3'd2;
  localparam logic [STATE_W-1:0] MEMORY    = 3'd3;
  localparam logic [STATE_W-1:0] WRITEBACK = 3'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
  } trace_entry_t;

endpackage

// File: rtl/trace_capture_if.sv
// Read-side handshake of the trace FIFO: the capture block is master, the host drain is slave.
interface trace_capture_if;
  import trace_pkg::*;

  logic         rd_valid;
  logic         rd_ready;
  trace_entry_t rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);

endinterface

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO; level is tracked in its own counter, independent of the pointers.
module trace_fifo #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    if (do_push && !do_pop) begin
      level_nxt = level + 1'b1;
    end else if (!do_push && do_pop) begin
      level_nxt = level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      full  <= (level_nxt == (AW+1)'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

  // Storage is not reset; entries are only observable through the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/trace_capture.sv
// Retirement tracer: detects fetch re-entry, logs {pc, result} and keeps retire/drop statistics.
module trace_capture import trace_pkg::*; #(
  parameter  int unsigned        DEPTH      = 16,
  parameter  logic [STATE_W-1:0] TRIG_STATE = FETCH,
  localparam int unsigned        AW         = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic [STATE_W-1:0] state_in,
  input  logic [31:0]        pc_in,
  input  logic [31:0]        result_in,
  trace_capture_if.master    rd,
  output logic [AW:0]        level,
  output logic               full,
  output logic               overflow,
  output logic [7:0]         drop_count,
  output logic [31:0]        retire_count
);

  logic [STATE_W-1:0] prev_state;
  logic               evt;
  logic               pop;
  logic               push;
  logic               drop;
  logic               fifo_empty;
  trace_entry_t       entry;

  assign entry = '{pc: pc_in, result: result_in};

  // Retirement = rising entry into the trigger state.
  assign evt  = enable && (state_in == TRIG_STATE) && (prev_state != TRIG_STATE);
  assign pop  = !fifo_empty && rd.rd_ready;
  assign push = evt && (!full || pop);
  assign drop = evt && full && !pop;

  assign rd.rd_valid = !fifo_empty;

  trace_fifo #(
    .WIDTH (TRACE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (clear),
    .push  (push),
    .din   (entry),
    .pop   (rd.rd_ready),
    .dout  (rd.rd_data),
    .level (level),
    .full  (full),
    .empty (fifo_empty)
  );

  // prev_state keeps tracking through clear so a clear never fabricates an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_state   <= TRIG_STATE;
      overflow     <= 1'b0;
      drop_count   <= '0;
      retire_count <= '0;
    end else begin
      prev_state <= state_in;
      if (clear) begin
        overflow     <= 1'b0;
        drop_count   <= '0;
        retire_count <= '0;
      end else begin
        if (evt) retire_count <= retire_count + 1'b1;
        if (drop) begin
          overflow <= 1'b1;
          if (drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_trace_capture.sv
// Self-checking bench for trace_capture: scoreboard of expected entries plus directed checks.
module tb_trace_capture;
  import trace_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        clear = 1'b0;
  logic [2:0]  state_in = 3'd0;
  logic [31:0] pc_in = '0;
  logic [31:0] result_in = '0;
  logic [4:0]  level;
  logic        full;
  logic        overflow;
  logic [7:0]  drop_count;
  logic [31:0] retire_count;

  int errors = 0;
  int checks = 0;

  logic [63:0] sb [$];
  logic [2:0]  m_prev = FETCH;

  trace_capture_if rd_bus();

  trace_capture #(.DEPTH(16), .TRIG_STATE(3'd0)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .clear        (clear),
    .state_in     (state_in),
    .pc_in        (pc_in),
    .result_in    (result_in),
    .rd           (rd_bus),
    .level        (level),
    .full         (full),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  // Advance one clock, updating the reference queue with what the edge should do.
  task automatic tick();
    logic pop_m, evt_m, full_m;
    if (reset) begin
      sb.delete();
      m_prev = FETCH;
    end else if (clear) begin
      sb.delete();
      m_prev = state_in;
    end else begin
      full_m = (sb.size() == 16);
      pop_m  = (sb.size() != 0) && rd_bus.rd_ready;
      evt_m  = enable && (state_in == FETCH) && (m_prev != FETCH);
      if (pop_m) void'(sb.pop_front());
      if (evt_m && (!full_m || pop_m)) sb.push_back({pc_in, result_in});
      m_prev = state_in;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] res);
    state_in = 3'd1;
    tick();
    state_in = 3'd0;
    pc_in = pc;
    result_in = res;
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (rd_bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rd_bus.rd_valid); end
    checks++; if ({full, overflow, drop_count} !== 10'd0) begin errors++; $display("FAIL reset_flags: full=%b ovf=%b drops=%0d want 0", full, overflow, drop_count); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (level !== 5'd0 || retire_count !== 32'd0) begin errors++; $display("FAIL hold_fetch: level=%0d retire=%0d want 0/0", level, retire_count); end
  endtask

  task automatic test_single();
    state_in = 3'd1; tick();
    state_in = 3'd2; tick();
    state_in = 3'd0; pc_in = 32'h10; result_in = 32'hAB; tick();
    checks++; if (rd_bus.rd_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", rd_bus.rd_valid); end
    checks++; if (rd_bus.rd_data !== 64'h00000010_000000AB) begin errors++; $display("FAIL single_data: got %h want 00000010000000ab", rd_bus.rd_data); end
    checks++; if (retire_count !== 32'd1) begin errors++; $display("FAIL single_retire: got %0d want 1", retire_count); end
    checks++; if (sb.size() != 1 || rd_bus.rd_data !== sb[0]) begin errors++; $display("FAIL single_sb: got %h want %h", rd_bus.rd_data, sb.size() != 0 ? sb[0] : 64'hx); end
    rd_bus.rd_ready = 1'b1; tick(); rd_bus.rd_ready = 1'b0;
    checks++; if (rd_bus.rd_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL single_drain: valid=%b level=%0d want 0/0", rd_bus.rd_valid, level); end
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 0; i < 17; i++) retire(32'(32'h100 + i), 32'(i));
    checks++; if (level !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL ovf_level: level=%0d full=%b want 16/1", level, full); end
    checks++; if (overflow !== 1'b1 || drop_count !== 8'd1) begin errors++; $display("FAIL ovf_drop: ovf=%b drops=%0d want 1/1", overflow, drop_count); end
    checks++; if (retire_count !== 32'd17) begin errors++; $display("FAIL ovf_retire: got %0d want 17", retire_count); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (sb.size() == 0 || rd_bus.rd_valid !== 1'b1 || rd_bus.rd_data !== sb[0] ||
          rd_bus.rd_data[63:32] !== 32'(32'h100 + k)) begin
        errors++; $display("FAIL ovf_drain[%0d]: valid=%b got %h want pc %h", k, rd_bus.rd_valid, rd_bus.rd_data, 32'h100 + k);
      end
      rd_bus.rd_ready = 1'b1; tick();
    end
    rd_bus.rd_ready = 1'b0;
    checks++; if (rd_bus.rd_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL ovf_empty: valid=%b level=%0d want 0/0", rd_bus.rd_valid, level); end
  endtask

  task automatic test_full_push_pop();
    do_clear();
    for (int i = 0; i < 16; i++) retire(32'(32'h400 + i), 32'(i));
    state_in = 3'd1; tick();
    state_in = 3'd0; pc_in = 32'hBEEF; result_in = 32'h55; rd_bus.rd_ready = 1'b1;
    checks++; if (sb.size() == 0 || rd_bus.rd_data !== sb[0]) begin errors++; $display("FAIL fpp_head: got %h want %h", rd_bus.rd_data, sb.size() != 0 ? sb[0] : 64'hx); end
    tick();
    rd_bus.rd_ready = 1'b0;
    checks++; if (level !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL fpp_level: level=%0d full=%b want 16/1", level, full); end
    checks++; if (drop_count !== 8'd0 || overflow !== 1'b0) begin errors++; $display("FAIL fpp_drop: drops=%0d ovf=%b want 0/0", drop_count, overflow); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (sb.size() == 0 || rd_bus.rd_data !== sb[0] || (k == 15 && rd_bus.rd_data !== 64'h0000BEEF_00000055)) begin
        errors++; $display("FAIL fpp_drain[%0d]: got %h want %h", k, rd_bus.rd_data, sb.size() != 0 ? sb[0] : 64'hx);
      end
      rd_bus.rd_ready = 1'b1; tick();
    end
    rd_bus.rd_ready = 1'b0;
  endtask

  task automatic test_saturate();
    do_clear();
    for (int i = 0; i < 316; i++) retire(32'(i), 32'(~i));
    checks++; if (drop_count !== 8'd255 || overflow !== 1'b1) begin errors++; $display("FAIL sat_drop: drops=%0d ovf=%b want 255/1", drop_count, overflow); end
    checks++; if (retire_count !== 32'd316 || level !== 5'd16) begin errors++; $display("FAIL sat_retire: retire=%0d level=%0d want 316/16", retire_count, level); end
    checks++; if (sb.size() == 0 || rd_bus.rd_data !== 64'h00000000_FFFFFFFF) begin errors++; $display("FAIL sat_head: got %h want 00000000ffffffff", rd_bus.rd_data); end
    do_clear();
    checks++; if (level !== 5'd0 || overflow !== 1'b0 || drop_count !== 8'd0 || retire_count !== 32'd0 || rd_bus.rd_valid !== 1'b0) begin
      errors++; $display("FAIL sat_clear: level=%0d ovf=%b drops=%0d retire=%0d valid=%b want all 0", level, overflow, drop_count, retire_count, rd_bus.rd_valid);
    end
  endtask

  task automatic test_clear_with_evt();
    state_in = 3'd1; tick();
    state_in = 3'd0; pc_in = 32'hDEAD; clear = 1'b1; tick(); clear = 1'b0;
    checks++; if (level !== 5'd0 || retire_count !== 32'd0 || rd_bus.rd_valid !== 1'b0) begin errors++; $display("FAIL clr_evt: level=%0d retire=%0d valid=%b want 0/0/0", level, retire_count, rd_bus.rd_valid); end
    tick();
    checks++; if (retire_count !== 32'd0) begin errors++; $display("FAIL clr_prev: retire=%0d want 0", retire_count); end
  endtask

  task automatic test_enable();
    do_clear();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) retire(32'(32'h600 + i), 32'(i));
    enable = 1'b1;
    retire(32'h200, 32'h2);
    checks++; if (retire_count !== 32'd1 || level !== 5'd1) begin errors++; $display("FAIL en_count: retire=%0d level=%0d want 1/1", retire_count, level); end
    checks++; if (sb.size() != 1 || rd_bus.rd_data !== 64'h00000200_00000002) begin errors++; $display("FAIL en_data: got %h want 0000020000000002", rd_bus.rd_data); end
    do_clear();
  endtask

  task automatic test_empty_push_pop();
    rd_bus.rd_ready = 1'b1;
    tick(); tick();
    checks++; if (level !== 5'd0 || rd_bus.rd_valid !== 1'b0) begin errors++; $display("FAIL empty_ready: level=%0d valid=%b want 0/0", level, rd_bus.rd_valid); end
    retire(32'h300, 32'h3);
    checks++; if (level !== 5'd1 || rd_bus.rd_valid !== 1'b1 || rd_bus.rd_data !== 64'h00000300_00000003) begin
      errors++; $display("FAIL empty_push: level=%0d valid=%b data=%h want 1/1/0000030000000003", level, rd_bus.rd_valid, rd_bus.rd_data);
    end
    rd_bus.rd_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) retire(32'(32'h700 + i), 32'(i));
    checks++; if (level !== 5'd5 || sb.size() != 5) begin errors++; $display("FAIL mid_level: level=%0d want 5", level); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (rd_bus.rd_valid !== 1'b0 || level !== 5'd0 || retire_count !== 32'd0) begin
      errors++; $display("FAIL mid_reset: valid=%b level=%0d retire=%0d want 0/0/0", rd_bus.rd_valid, level, retire_count);
    end
    tick();
    checks++; if (retire_count !== 32'd0) begin errors++; $display("FAIL mid_first_fetch: retire=%0d want 0", retire_count); end
  endtask

  initial begin
    rd_bus.rd_ready = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_saturate();
    test_clear_with_evt();
    test_enable();
    test_empty_push_pop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trace_capture.md
Name: trace_capture

Overview:
- Downstream observer of the multi-cycle core top level. Consumes the core's state, PC and RESULT outputs.
- Detects each instruction retirement, i.e. each re-entry into the fetch state.
- Logs {PC, RESULT} pairs into a show-ahead FIFO that a debug/host port drains with a valid/ready handshake.
- Also keeps a free-running retire counter and overflow/drop statistics.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >=2.
- TRIG_STATE, 3'd0, controller state code for fetch; entry into it marks a retirement.
- AW, $clog2(DEPTH), derived FIFO pointer width; not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  capture enable; low suppresses capture events.
- clear  in  1  synchronous flush of the FIFO and statistics.
- state_in  in  3  controller state from core.
- pc_in  in  32  core PC.
- result_in  in  32  core RESULT.
- rd_ready  in  1  consumer accepts the head entry.
- rd_valid  out  1  FIFO non-empty.
- rd_data  out  64  head entry {pc[63:32], result[31:0]}.
- level  out  AW+1  entries held, 0..DEPTH.
- full  out  1  level==DEPTH.
- overflow  out  1  sticky; set when an event is dropped.
- drop_count  out  8  dropped events, saturating at 255.
- retire_count  out  32  capture events seen (stored + dropped), wraps.

Behaviour:
- One clock domain. Reset is synchronous, active-high, and has highest priority. clear is next; clear has the same effect as reset except that prev_state is still updated.
- Reset/clear values:
  - level=0, rd_valid=0, full=0, overflow=0, drop_count=0, retire_count=0.
  - Pointers = 0.
  - prev_state=TRIG_STATE on reset only.
  - rd_data = don't-care while rd_valid=0; bench must not check it.
- prev_state register samples state_in every cycle.
- Capture event (evt) = enable && state_in==TRIG_STATE && prev_state!=TRIG_STATE. The first fetch after reset is therefore not an event.
- On an evt cycle, pc_in/result_in are sampled at the same edge, holding the values at fetch entry.
- Push = evt && (!full || pop). Pop = rd_valid && rd_ready.
- Latency: an entry pushed at edge N is visible with rd_valid=1 from cycle N+1; rd_data is a combinational read of mem[rd_ptr].
- Boundary cases:
  - Simultaneous push and pop while full: both happen, level stays DEPTH, no drop.
  - Simultaneous push and pop while empty: push only, since rd_valid=0 means no pop.
  - evt while full without pop: entry discarded; overflow<=1; drop_count+=1 (saturates at 255); FIFO contents unchanged.
  - Pointers wrap modulo DEPTH; level is tracked separately, never derived from the pointers alone.
- retire_count increments on every evt and wraps 0xFFFFFFFF->0.
- clear asserted in the same cycle as evt: clear wins, no entry stored, retire_count=0.
- Reset mid-stream discards all entries immediately; rd_valid is 0 in the next cycle.
- rd_ready while empty is ignored.
- No combinational path from rd_ready to any output.

Decomposition:
- Shared package (trace_pkg):
  - TRACE_W=64.
  - State code localparams (FETCH=3'd0, ...) shared with the controller.
  - trace entry struct {pc, result}.
- One natural sub-module: trace_fifo. Generic synchronous show-ahead FIFO with parameter WIDTH/DEPTH and push/pop/level/full/empty.
- trace_capture holds the edge detector, statistics and drop logic.

Test Plan:
- Directed scenarios:
  - Reset, then state_in held at 0 for 5 cycles -> no evt; level=0, retire_count=0.
  - state_in sequence 0,1,2,0 with pc_in=0x10, result_in=0xAB at the final 0 -> next cycle rd_valid=1, rd_data=0x00000010_000000AB, retire_count=1.
  - 17 retirements, DEPTH=16, rd_ready=0 -> level=16, full=1, overflow=1, drop_count=1, retire_count=17. Drain shows the first 16 PCs in order.
  - With full FIFO, evt coincident with rd_ready=1 -> level stays 16, drop_count unchanged, new entry appears at the tail.
  - 300 drops while full -> drop_count=255. Then clear -> level=0, overflow=0, drop_count=0, retire_count=0.
  - enable=0 across 3 retirements, then enable=1 for 1 retirement -> retire_count=1, one entry. Also: reset asserted with 5 entries queued -> next cycle rd_valid=0, level=0.
